// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - next-PC sequencing control with stall-tolerant redirect hold (optional PC_REDIRECT_CNT_EN counter)
module pc_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        valid_e,
  input  logic        jump_e,
  input  logic        jr_e,
  input  logic        branch_e,
  input  logic        taken_e,
  output logic [1:0]  pc_sel,
  output logic        pc_we,
  output logic        flush_fd,
  output logic        redirect_pend,
  output logic [15:0] redirect_cnt
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_J   = 2'b01;
  localparam logic [1:0] SEL_JR  = 2'b10;
  localparam logic [1:0] SEL_BR  = 2'b11;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [1:0] r_held_sel;
  logic       w_req;
  logic [1:0] w_req_sel;

  // Redirect request from E and its select, JR winning over J over taken branch
  always_comb begin
    w_req = valid_e & (jr_e | jump_e | (branch_e & taken_e));
    if (jr_e)
      w_req_sel = SEL_JR;
    else if (jump_e)
      w_req_sel = SEL_J;
    else
      w_req_sel = SEL_BR;
  end

  // Output decode and next state; a redirect commits in the same cycle unless stalled
  always_comb begin
    w_next_state  = r_state;
    pc_sel        = SEL_SEQ;
    pc_we         = 1'b0;
    flush_fd      = 1'b0;
    redirect_pend = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_req) begin
          pc_sel = w_req_sel;
          if (!stall) begin
            pc_we    = 1'b1;
            flush_fd = 1'b1;
          end else begin
            w_next_state = ST_HOLD;
          end
        end else begin
          pc_we = ~stall;
        end
      end
      ST_HOLD: begin
        pc_sel        = r_held_sel;
        redirect_pend = 1'b1;
        if (!stall) begin
          pc_we        = 1'b1;
          flush_fd     = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      default: begin
        // BOOT (and any unused encoding): keep F/D flushed, PC frozen
        flush_fd     = 1'b1;
        w_next_state = ST_RUN;
      end
    endcase
  end

  // State register; reset lands in BOOT so the first released cycle is BOOT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_BOOT;
    else
      r_state <= w_next_state;
  end

  // Held select: captured when a redirect meets a stall, cleared when it commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_held_sel <= SEL_SEQ;
    else if ((r_state == ST_RUN) && w_req && stall)
      r_held_sel <= w_req_sel;
    else if ((r_state == ST_HOLD) && !stall)
      r_held_sel <= SEL_SEQ;
  end

`ifdef PC_REDIRECT_CNT_EN
  logic        w_commit;
  logic [15:0] r_redirect_cnt;

  assign w_commit = pc_we & flush_fd & (r_state != ST_BOOT);

  // Saturating count of committed redirects
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_redirect_cnt <= 16'h0000;
    else if (w_commit && (r_redirect_cnt != 16'hFFFF))
      r_redirect_cnt <= r_redirect_cnt + 16'h0001;
  end

  assign redirect_cnt = r_redirect_cnt;
`else
  assign redirect_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - directed and random checks of pc_seq_ctrl against a behavioural model
module tb_pc_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        valid_e;
  logic        jump_e;
  logic        jr_e;
  logic        branch_e;
  logic        taken_e;
  logic [1:0]  pc_sel;
  logic        pc_we;
  logic        flush_fd;
  logic        redirect_pend;
  logic [15:0] redirect_cnt;

  int total;
  int bad;

  // behavioural model: booting flag, optional pending redirect, commit count
  bit         m_boot;
  bit         m_pend;
  logic [1:0] m_sel;
  int         m_cnt;

  pc_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .valid_e       (valid_e),
    .jump_e        (jump_e),
    .jr_e          (jr_e),
    .branch_e      (branch_e),
    .taken_e       (taken_e),
    .pc_sel        (pc_sel),
    .pc_we         (pc_we),
    .flush_fd      (flush_fd),
    .redirect_pend (redirect_pend),
    .redirect_cnt  (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef PC_REDIRECT_CNT_EN
    return 16'(m_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic step(input logic s, input logic v, input logic j, input logic r,
                      input logic b, input logic t, input string tag);
    logic       req;
    logic [1:0] rsel;
    logic [1:0] e_sel;
    logic       e_we;
    logic       e_fl;
    logic       e_pend;
    @(negedge clk);
    stall = s; valid_e = v; jump_e = j; jr_e = r; branch_e = b; taken_e = t;
    #1;
    req  = v & (r | j | (b & t));
    rsel = r ? 2'b10 : (j ? 2'b01 : 2'b11);
    if (m_boot) begin
      e_sel = 2'b00; e_we = 1'b0; e_fl = 1'b1; e_pend = 1'b0;
    end else if (m_pend) begin
      e_sel = m_sel; e_we = ~s; e_fl = ~s; e_pend = 1'b1;
    end else if (req) begin
      e_sel = rsel; e_we = ~s; e_fl = ~s; e_pend = 1'b0;
    end else begin
      e_sel = 2'b00; e_we = ~s; e_fl = 1'b0; e_pend = 1'b0;
    end
    chk({tag, ".pc_sel"}, 16'(pc_sel), 16'(e_sel));
    chk({tag, ".pc_we"}, 16'(pc_we), 16'(e_we));
    chk({tag, ".flush_fd"}, 16'(flush_fd), 16'(e_fl));
    chk({tag, ".pend"}, 16'(redirect_pend), 16'(e_pend));
    chk({tag, ".cnt"}, redirect_cnt, exp_cnt());
    @(posedge clk);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_pend) begin
      if (!s) begin
        m_pend = 1'b0;
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (req) begin
      if (!s) begin
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_pend = 1'b1;
        m_sel  = rsel;
      end
    end
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk({tag, ".rst_sel"}, 16'(pc_sel), 16'h0);
    chk({tag, ".rst_we"}, 16'(pc_we), 16'h0);
    chk({tag, ".rst_fl"}, 16'(flush_fd), 16'h1);
    chk({tag, ".rst_pend"}, 16'(redirect_pend), 16'h0);
    chk({tag, ".rst_cnt"}, redirect_cnt, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_boot = 1'b1; m_pend = 1'b0; m_sel = 2'b00; m_cnt = 0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; stall = 1'b0; valid_e = 1'b0; jump_e = 1'b0;
    jr_e = 1'b0; branch_e = 1'b0; taken_e = 1'b0;
    #1;
    chk("por.sel", 16'(pc_sel), 16'h0);
    chk("por.we", 16'(pc_we), 16'h0);
    chk("por.fl", 16'(flush_fd), 16'h1);
    chk("por.pend", 16'(redirect_pend), 16'h0);
    chk("por.cnt", redirect_cnt, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_boot = 1'b1; m_pend = 1'b0; m_sel = 2'b00; m_cnt = 0;

    // boot then sequential fetch
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, "boot_seq");

    // taken branch, zero latency
    step(0, 1, 0, 0, 1, 1, "br_taken");
    step(0, 0, 0, 0, 0, 0, "br_after");

    // JR and J together under a 3-cycle stall
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 0, "jr_stall");
    step(0, 1, 1, 1, 0, 0, "jr_release");
    step(0, 0, 0, 0, 0, 0, "jr_after");

    // priority: jump over taken branch, jr over branch
    step(0, 1, 1, 0, 1, 1, "j_over_br");
    step(0, 1, 0, 1, 1, 1, "jr_over_br");

    // reset while holding a J redirect
    step(1, 1, 1, 0, 0, 0, "hold_cap");
    step(1, 1, 1, 0, 0, 0, "hold_j");
    apply_reset("hold_rst");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, "post_rst");

    // non-requests
    step(0, 1, 0, 0, 1, 0, "br_not_taken");
    step(0, 0, 1, 0, 0, 0, "j_bubble");
    step(0, 0, 0, 1, 1, 1, "all_bubble");
    step(1, 0, 0, 0, 0, 0, "idle_stall");

    // random mix with occasional resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0)
        apply_reset("rnd_rst");
      else
        step(($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    // saturation: more than 65535 back-to-back redirects
    apply_reset("sat_rst");
    for (int i = 0; i < 65540; i++) step(0, 1, 1, 0, 0, 0, "sat");
    step(0, 0, 0, 0, 0, 0, "sat_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
